// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF evaluator: RESP_W RO pairs, one bit per pair (cnt0 > cnt1) plus a tie mask.
// Latency: resp_valid arrives 1 + RESP_W*(SETTLE+WINDOW+1) cycles after start is accepted.
// Backpressure: none; start is taken only in IDLE and ignored while busy.
module ro_puf_eval #(
    parameter int NUM_RO = 256,
    parameter int SEL_W  = $clog2(NUM_RO),
    parameter int RESP_W = 8,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1024,
    parameter int SETTLE = 16
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic [NUM_RO-1:0] ro_bank0,
    input  logic [NUM_RO-1:0] ro_bank1,
    output logic              ro_en,
    input  logic              start,
    input  logic [SEL_W-1:0]  challenge,
    output logic              busy,
    output logic              resp_valid,
    output logic [RESP_W-1:0] response,
    output logic [RESP_W-1:0] tie_mask,
    output logic [CNT_W-1:0]  last_cnt0,
    output logic [CNT_W-1:0]  last_cnt1
);

    localparam int IDX_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int TMR_W = 20;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   base;
    logic [SEL_W-1:0]   sel;
    logic [IDX_W-1:0]   idx;
    logic [TMR_W-1:0]   tmr;
    logic [CNT_W-1:0]   cnt0, cnt1;
    logic [2:0]         sync0, sync1;
    logic               edge0, edge1;

    // The select only moves when idx advances in COMPARE, so the mux is stable across SETTLE/COUNT.
    assign sel = base + SEL_W'(idx);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) state <= S_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ro_en      = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                ro_en = 1'b1;
                if (tmr == SETTLE_LAST) state_nxt = S_COUNT;
            end
            S_COUNT: begin
                ro_en = 1'b1;
                if (tmr == WINDOW_LAST) state_nxt = S_COMPARE;
            end
            S_COMPARE: state_nxt = (idx == IDX_LAST) ? S_DONE : S_SETTLE;
            S_DONE: begin
                resp_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Two synchronizer flops, one history flop, then a registered edge pulse: 3-cycle path for both banks.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync0 <= '0;
            sync1 <= '0;
            edge0 <= 1'b0;
            edge1 <= 1'b0;
        end else begin
            sync0 <= {sync0[1:0], ro_bank0[sel]};
            sync1 <= {sync1[1:0], ro_bank1[sel]};
            edge0 <= sync0[1] & ~sync0[2];
            edge1 <= sync1[1] & ~sync1[2];
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            tmr       <= '0;
            cnt0      <= '0;
            cnt1      <= '0;
            base      <= '0;
            idx       <= '0;
            response  <= '0;
            tie_mask  <= '0;
            last_cnt0 <= '0;
            last_cnt1 <= '0;
        end else begin
            if (state != state_nxt) tmr <= '0;
            else if (state == S_SETTLE || state == S_COUNT) tmr <= tmr + TMR_W'(1);

            if (state == S_COUNT) begin
                if (edge0 && cnt0 != '1) cnt0 <= cnt0 + CNT_W'(1);
                if (edge1 && cnt1 != '1) cnt1 <= cnt1 + CNT_W'(1);
            end else if (state != S_COMPARE) begin
                cnt0 <= '0;
                cnt1 <= '0;
            end

            if (state == S_IDLE && start) begin
                base     <= challenge;
                idx      <= '0;
                response <= '0;
                tie_mask <= '0;
            end

            if (state == S_COMPARE) begin
                response[idx] <= (cnt0 > cnt1);
                tie_mask[idx] <= (cnt0 == cnt1);
                last_cnt0     <= cnt0;
                last_cnt1     <= cnt1;
                if (idx != IDX_LAST) idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ro_puf_eval.sv
// Scoreboarded bench for ro_puf_eval: a 16-bit-counter and a 4-bit-counter (saturating) instance share stimulus.
module tb_ro_puf_eval;
    localparam int NRO  = 16;
    localparam int RW   = 4;
    localparam int WIN  = 64;
    localparam int ST   = 4;
    localparam int LAT  = 1 + RW * (ST + WIN + 1);
    localparam int MAXA = 65535;
    localparam int MAXB = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [NRO-1:0]  b0 = '0, b1 = '0;
    logic            start;
    logic [3:0]      chal;

    logic            ro_en_a, busy_a, rv_a;
    logic [RW-1:0]   resp_a, tie_a;
    logic [15:0]     lc0_a, lc1_a;
    logic            ro_en_b, busy_b, rv_b;
    logic [RW-1:0]   resp_b, tie_b;
    logic [3:0]      lc0_b, lc1_b;

    ro_puf_eval #(.NUM_RO(NRO), .RESP_W(RW), .CNT_W(16), .WINDOW(WIN), .SETTLE(ST)) dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .ro_bank0(b0), .ro_bank1(b1), .ro_en(ro_en_a),
        .start(start), .challenge(chal), .busy(busy_a), .resp_valid(rv_a), .response(resp_a),
        .tie_mask(tie_a), .last_cnt0(lc0_a), .last_cnt1(lc1_a)
    );

    ro_puf_eval #(.NUM_RO(NRO), .RESP_W(RW), .CNT_W(4), .WINDOW(WIN), .SETTLE(ST)) dut_sat (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .ro_bank0(b0), .ro_bank1(b1), .ro_en(ro_en_b),
        .start(start), .challenge(chal), .busy(busy_b), .resp_valid(rv_b), .response(resp_b),
        .tie_mask(tie_b), .last_cnt0(lc0_b), .last_cnt1(lc1_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RO periods in clock cycles, per bank and per index.
    int p0[NRO] = '{default: 8};
    int p1[NRO] = '{default: 8};

    // Square waves derived from a common time base, so equal periods give identical waveforms.
    always @(negedge clk) begin
        for (int j = 0; j < NRO; j++) begin
            b0[j] = ro_en_a && ((cyc % p0[j]) < (p0[j] / 2));
            b1[j] = ro_en_a && ((cyc % p1[j]) < (p1[j] / 2));
        end
    end

    typedef struct {
        int         t;
        logic [3:0] resp;
        logic [3:0] tie;
        int         r0;
        int         r1;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int n_chk  = 0;
    int n_fail = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Edges in the window are WIN/period; a saturating counter clips at maxc.
    function automatic exp_t model(input int base, input int t, input int maxc);
        exp_t e;
        int   s, n0, n1;
        e.t = t; e.resp = '0; e.tie = '0; e.r0 = 0; e.r1 = 0;
        for (int k = 0; k < RW; k++) begin
            s    = (base + k) % NRO;
            e.r0 = WIN / p0[s];
            e.r1 = WIN / p1[s];
            n0   = imin(e.r0, maxc);
            n1   = imin(e.r1, maxc);
            e.resp[k] = (n0 > n1);
            e.tie[k]  = (n0 == n1);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic check_eval(input string tag, input exp_t e, input int maxc,
                              input int rsp, input int tie, input int c0, input int c1);
        chk({tag, " latency"}, cyc, e.t);
        chk({tag, " response"}, rsp, int'(e.resp));
        chk({tag, " tie_mask"}, tie, int'(e.tie));
        chk_rng({tag, " last_cnt0"}, c0, imin(e.r0 - 1, maxc), imin(e.r0 + 1, maxc));
        chk_rng({tag, " last_cnt1"}, c1, imin(e.r1 - 1, maxc), imin(e.r1 + 1, maxc));
    endtask

    // Monitor: every resp_valid pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rv_a) begin
                if (qa.size() == 0) chk("unexpected resp_valid cnt16", 1, 0);
                else begin
                    e = qa.pop_front();
                    check_eval("cnt16", e, MAXA, int'(resp_a), int'(tie_a), int'(lc0_a), int'(lc1_a));
                end
            end
            if (rv_b) begin
                if (qb.size() == 0) chk("unexpected resp_valid cnt4", 1, 0);
                else begin
                    e = qb.pop_front();
                    check_eval("cnt4", e, MAXB, int'(resp_b), int'(tie_b), int'(lc0_b), int'(lc1_b));
                end
            end
        end
    end

    task automatic issue(input int ch, input bit accepted);
        @(negedge clk);
        chal  = 4'(ch);
        start = 1'b1;
        if (accepted) begin
            qa.push_back(model(ch, cyc + LAT, MAXA));
            qb.push_back(model(ch, cyc + LAT, MAXB));
        end
        @(negedge clk);
        start = 1'b0;
        chal  = 4'($urandom_range(0, NRO - 1));
    endtask

    task automatic wait_done();
        for (int k = 0; k < 2 * LAT; k++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(negedge clk);
        end
        chk("pending results at timeout", qa.size() + qb.size(), 0);
        qa.delete();
        qb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_periods();
        for (int j = 0; j < NRO; j++) begin
            p0[j] = 4 << $urandom_range(0, 2);
            p1[j] = 4 << $urandom_range(0, 2);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ro_en"}, int'(ro_en_a) + int'(ro_en_b), 0);
        chk({tag, " busy"}, int'(busy_a) + int'(busy_b), 0);
        chk({tag, " resp_valid"}, int'(rv_a) + int'(rv_b), 0);
        chk({tag, " response"}, int'(resp_a) + int'(resp_b), 0);
        chk({tag, " tie_mask"}, int'(tie_a) + int'(tie_b), 0);
        chk({tag, " last_cnt0"}, int'(lc0_a) + int'(lc0_b), 0);
        chk({tag, " last_cnt1"}, int'(lc1_a) + int'(lc1_b), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        chal  = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle busy", int'(busy_a), 0);

        // Basic: bank0 twice as fast everywhere.
        for (int j = 0; j < NRO; j++) begin p0[j] = 4; p1[j] = 8; end
        issue(0, 1);
        wait_done();

        // Select wrap: only ROs 14 and 1 differ.
        for (int j = 0; j < NRO; j++) begin p0[j] = 8; p1[j] = 8; end
        p0[14] = 4;
        p0[1]  = 4;
        issue(14, 1);
        wait_done();

        // Start while busy is ignored; the result comes from base 5.
        rand_periods();
        issue(5, 1);
        repeat (30) @(negedge clk);
        chk("busy mid-count", int'(busy_a), 1);
        issue(9, 0);
        wait_done();

        // Reset during the second pair's window aborts everything.
        rand_periods();
        issue(3, 1);
        repeat (ST + WIN + 1 + ST + 10) @(negedge clk);
        chk("ro_en before abort", int'(ro_en_a), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        qa.delete();
        qb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(int'($urandom_range(0, NRO - 1)), 1);
        wait_done();

        for (int r = 0; r < 4; r++) begin
            rand_periods();
            issue(int'($urandom_range(0, NRO - 1)), 1);
            wait_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ro_puf_eval.md
# ro_puf_eval

Parametrised ring-oscillator PUF evaluator, the counter-based successor to the raw mux-to-LED RO PUF top. It accepts a challenge and enables two external RO banks of `NUM_RO` oscillators each. For each of `RESP_W` successive RO pairs, it counts rising edges from the selected bank-0 and bank-1 oscillators over a fixed window and compares the counts. It then returns a `RESP_W`-bit response with a per-bit tie mask through a start/valid handshake, and sits between the RO arrays and the board-level switch/button/LED logic.

## Interface
- `NUM_RO`, 256: oscillators per bank; power of two, ≥2.
- `SEL_W`, $clog2(NUM_RO): challenge/select width.
- `RESP_W`, 8: response bits per evaluation; 1..NUM_RO.
- `CNT_W`, 16: edge-counter width.
- `WINDOW`, 1024: count-window length in clock cycles; ≥1, < 2^20.
- `SETTLE`, 16: RO settle cycles before each window; ≥1.

Ports:
- `CLK100MHZ` in 1: single clock.
- `CPU_RESETN` in 1: asynchronous, active-low reset.
- `ro_bank0` in NUM_RO: bank-0 RO outputs; asynchronous to the clock.
- `ro_bank1` in NUM_RO: bank-1 RO outputs; asynchronous to the clock.
- `ro_en` out 1: enable to both RO banks.
- `start` in 1: request an evaluation; sampled only in IDLE.
- `challenge` in SEL_W: base RO index; latched when `start` is accepted.
- `busy` out 1: high from the cycle after acceptance until DONE exits.
- `resp_valid` out 1: one-cycle pulse; `response` and `tie_mask` are valid from this cycle.
- `response` out RESP_W: bit i = 1 iff cnt0 > cnt1 for pair i.
- `tie_mask` out RESP_W: bit i = 1 iff cnt0 == cnt1 for pair i.
- `last_cnt0` out CNT_W: final bank-0 count of the most recent pair (debug).
- `last_cnt1` out CNT_W: final bank-1 count of the most recent pair (debug).

## Operation
- States: IDLE, SETTLE, COUNT, COMPARE, DONE.
- IDLE: `busy`=0, `ro_en`=0. When `start`=1:
  - latch `challenge` into `base`;
  - clear index `i`, `response` and `tie_mask`;
  - go to SETTLE.
- Pair i uses RO index `sel = (base + i) mod NUM_RO`; the addition wraps at SEL_W bits.
- The same `sel` drives both the bank-0 and bank-1 muxes.
- SETTLE:
  - `ro_en`=1; both counters held at 0;
  - lasts `SETTLE` cycles, then go to COUNT.
- Edge path:
  - each selected RO output passes through a 2-FF synchronizer, then a registered rising-edge detector;
  - the synchronizer and detector run in every state;
  - the ROs must be sized so their frequency is < CLK100MHZ/4; faster ROs alias, and that case is out of scope.
- COUNT:
  - `ro_en`=1; each counter increments on its own detected edge;
  - counters saturate at 2^CNT_W−1 and do not wrap;
  - lasts `WINDOW` cycles, then go to COMPARE.
- COMPARE (1 cycle):
  - `ro_en`=0;
  - write `response[i]` = (cnt0>cnt1) and `tie_mask[i]` = (cnt0==cnt1); a tie gives a response bit of 0;
  - copy the counters to `last_cnt0`/`last_cnt1`;
  - if i==RESP_W−1, go to DONE; else i++ and go to SETTLE.
- DONE (1 cycle): `resp_valid`=1, `busy`=1; then go to IDLE.
- `response`/`tie_mask` hold their value until the next accepted start clears them.
- `start` is ignored while `busy`=1. `challenge` changes after acceptance have no effect.
- `sel` changes only in COMPARE→SETTLE, so the mux is stable for the whole window.

## Timing
- Reset (async assert, sync deassert via the clock edge):
  - state=IDLE;
  - `ro_en`, `busy`, `resp_valid` = 0;
  - `response`, `tie_mask`, `last_cnt0`, `last_cnt1`, counters, `i`, `base` = 0;
  - synchronizer flops = 0.
- Reset mid-evaluation: the block aborts immediately, with no `resp_valid` and `ro_en` dropping asynchronously.
- Start accepted at cycle T:
  - SETTLE begins at T+1;
  - per-pair cost = SETTLE + WINDOW + 1 cycles;
  - `resp_valid` is at T + 1 + RESP_W·(SETTLE+WINDOW+1);
  - earliest next accept is 1 cycle after `resp_valid`.
- Edges up to the 3-cycle path delay at the window start are excluded; the same delay applies to both banks, so the comparison is unbiased.

## Test plan
- Bench parameters for all cases: NUM_RO=16, RESP_W=4, WINDOW=64, SETTLE=4, CNT_W=16. Bench square waves are gated by `ro_en`.
- Basic: bank0 period 4 and bank1 period 8 on all ROs; start with challenge=0.
  - Required: `resp_valid` exactly 4·69+1=277 cycles after accept.
  - Required: `response`=4'b1111, `tie_mask`=0, `last_cnt0`≈16, `last_cnt1`≈8 (±1).
- Wrap and select: challenge=14, bank0 faster only on ROs 14 and 1, all others equal period 8.
  - Required: `response`=4'b1001 (bits for sel 14, 15, 0, 1).
  - Required: `tie_mask`=4'b0110.
- Saturation: CNT_W=4, bank0 period 4 (16 edges), bank1 period 8.
  - Required: cnt0 saturates at 15; `last_cnt0`=15.
  - Required: `response` bits=1 (15>8).
- Busy handling: pulse `start` with challenge=5 and again mid-COUNT with challenge=9.
  - Required: the second start is ignored; only one `resp_valid`, with responses computed from base 5.
- Reset abort: assert `CPU_RESETN`=0 during pair 2's COUNT, then release and start again.
  - Required: outputs are at reset values immediately, with no `resp_valid`.
  - Required: the fresh evaluation completes with correct values.
